dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the single-port synchronous data memory between two requesters: the core load/store path (port c_) and a DMA/debug master (port d_). Grants at most one access per cycle. Fixed priority goes to the core, bounded by a starvation limit that guarantees DMA forward progress. Read data returns one cycle after grant and is routed to the requester that issued the read.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, consecutive contested core grants after which DMA wins the next contested cycle (range 1..15)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous reset, active-high (1 = reset)
c_req  input  1  core access request, held until c_gnt
c_we  input  1  core write enable (1 = store, 0 = load)
c_addr  input  ADDR_W  core byte address
c_wdata  input  DATA_W  core store data
c_be  input  DATA_W/8  core byte enables
c_gnt  output  1  core request accepted this cycle (combinational)
c_rvalid  output  1  core read data valid
c_rdata  output  DATA_W  core read data
d_req, d_we, d_addr, d_wdata, d_be  input  same widths  DMA request, same rules as core
d_gnt  output  1  DMA request accepted this cycle (combinational)
d_rvalid  output  1  DMA read data valid
d_rdata  output  DATA_W  DMA read data
m_en  output  1  memory access strobe
m_we  output  1  memory write enable
m_addr  output  ADDR_W  memory address
m_wdata  output  DATA_W  memory write data
m_be  output  DATA_W/8  memory byte enables
m_rdata  input  DATA_W  memory read data, valid the cycle after m_en with m_we=0

Behaviour:
- Reset (rst_n=1 at an edge): starve_cnt=0, rsp_owner=NONE, c_rvalid=d_rvalid=0. A read granted in the reset cycle produces no response.
- Grant logic, combinational, evaluated every cycle:
  - only c_req → c_gnt=1
  - only d_req → d_gnt=1
  - both requesting → core wins, unless starve_cnt==STARVE_LIMIT, in which case DMA wins
  - c_gnt and d_gnt are never both 1
- m_en = c_gnt|d_gnt. m_we/m_addr/m_wdata/m_be are muxed from the winner. When m_en=0: m_we=0 and all other m_* outputs are 0.
- Starvation counter (registered, 4 bits):
  - core granted while d_req=1 → starve_cnt+1, saturating at STARVE_LIMIT
  - DMA granted, or d_req=0 → starve_cnt=0
- Read response tracking (registered):
  - granted read (we=0) → rsp_owner=winner for the next cycle
  - otherwise rsp_owner=NONE
  - c_rvalid = (rsp_owner==CORE); d_rvalid = (rsp_owner==DMA)
- Read data routing:
  - c_rdata = m_rdata when c_rvalid=1, else 0
  - d_rdata = m_rdata when d_rvalid=1, else 0
- Latency:
  - read: grant in cycle N, rvalid+rdata in cycle N+1
  - write: memory updated at the end of cycle N, no response
  - back-to-back reads from alternating owners are supported at full rate
- Requester rule: req, we, addr, wdata and be stay stable from req rise until gnt. A request may not be withdrawn before it is granted. The arbiter does not check this rule.
- No internal buffering. Throughput is 1 access per cycle.
- Write-then-read of the same address in consecutive cycles returns the new data, relying on memory write-first ordering.

Test Plan:
1. Reset, then core read addr 0x10 (mem[0x10]=0xDEADBEEF) → c_gnt=1 in cycle 0, c_rvalid=1 with c_rdata=0xDEADBEEF in cycle 1, d_rvalid=0, d_rdata=0.
2. Core write 0x20←0x12345678 (be=4'hF), then DMA read 0x20 → m_we=1 in cycle 0, d_rvalid=1 with d_rdata=0x12345678 in cycle 2.
3. c_req and d_req held high for 12 cycles, STARVE_LIMIT=4 → grant pattern C,C,C,C,D repeating; at most 4 consecutive core grants; never both gnt in one cycle.
4. Alternating reads C@0x0, D@0x4, C@0x8 in consecutive cycles → rvalid alternates core/DMA in cycles 1..3, each with correct data; no cross-routing.
5. Core read granted in cycle N, rst_n=1 in cycle N+1 → c_rvalid=0 in cycles N+1 and N+2, starve_cnt=0 after reset.
6. DMA partial write be=4'b0010, data 0x0000AB00, to 0x30 (old value 0xFFFFFFFF), then read back → 0xFFFFABFF.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The arbiter uses the slave view; the environment around it uses the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W/8-1:0] c_be;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W/8-1:0] m_be;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_be,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata, m_be,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_be,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_be,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data memory: core has priority,
// DMA is guaranteed a slot after STARVE_LIMIT consecutive contested core grants.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam int          BE_W  = DATA_W / 8;
  localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  owner_t      rsp_owner_reg;
  logic [3:0]  starve_cnt_reg;
  logic        c_rvalid_reg;
  logic        d_rvalid_reg;

  logic              dma_turn;
  logic              c_gnt_w;
  logic              d_gnt_w;
  logic              m_we_w;
  logic [ADDR_W-1:0] m_addr_w;
  logic [DATA_W-1:0] m_wdata_w;
  logic [BE_W-1:0]   m_be_w;

  assign dma_turn = (starve_cnt_reg == LIMIT);
  assign c_gnt_w  = bus.c_req & (~bus.d_req | ~dma_turn);
  assign d_gnt_w  = bus.d_req & (~bus.c_req |  dma_turn);

  // Idle cycles drive all-zero memory controls so nothing stale reaches the RAM.
  always_comb begin
    m_we_w    = 1'b0;
    m_addr_w  = '0;
    m_wdata_w = '0;
    m_be_w    = '0;
    if (c_gnt_w) begin
      m_we_w    = bus.c_we;
      m_addr_w  = bus.c_addr;
      m_wdata_w = bus.c_wdata;
      m_be_w    = bus.c_be;
    end else if (d_gnt_w) begin
      m_we_w    = bus.d_we;
      m_addr_w  = bus.d_addr;
      m_wdata_w = bus.d_wdata;
      m_be_w    = bus.d_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      starve_cnt_reg <= 4'd0;
      rsp_owner_reg  <= OWN_NONE;
      c_rvalid_reg   <= 1'b0;
      d_rvalid_reg   <= 1'b0;
    end else begin
      if (c_gnt_w && bus.d_req)
        starve_cnt_reg <= (starve_cnt_reg == LIMIT) ? starve_cnt_reg : starve_cnt_reg + 4'd1;
      else
        starve_cnt_reg <= 4'd0;

      // The read response belongs to whoever won this cycle's read.
      if (c_gnt_w && !bus.c_we) begin
        rsp_owner_reg <= OWN_CORE;
        c_rvalid_reg  <= 1'b1;
        d_rvalid_reg  <= 1'b0;
      end else if (d_gnt_w && !bus.d_we) begin
        rsp_owner_reg <= OWN_DMA;
        c_rvalid_reg  <= 1'b0;
        d_rvalid_reg  <= 1'b1;
      end else begin
        rsp_owner_reg <= OWN_NONE;
        c_rvalid_reg  <= 1'b0;
        d_rvalid_reg  <= 1'b0;
      end
    end
  end

  assign bus.c_gnt    = c_gnt_w;
  assign bus.d_gnt    = d_gnt_w;
  assign bus.m_en     = c_gnt_w | d_gnt_w;
  assign bus.m_we     = m_we_w;
  assign bus.m_addr   = m_addr_w;
  assign bus.m_wdata  = m_wdata_w;
  assign bus.m_be     = m_be_w;
  assign bus.c_rvalid = c_rvalid_reg && (rsp_owner_reg == OWN_CORE);
  assign bus.d_rvalid = d_rvalid_reg && (rsp_owner_reg == OWN_DMA);

  // Read data is zeroed per byte lane for the requester that does not own the response.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      assign bus.c_rdata[gi*8 +: 8] = bus.c_rvalid ? bus.m_rdata[gi*8 +: 8] : 8'h00;
      assign bus.d_rdata[gi*8 +: 8] = bus.d_rvalid ? bus.m_rdata[gi*8 +: 8] : 8'h00;
    end
  endgenerate
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for starvation and reset-during-read.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous single-port memory, byte-enable writes, one-cycle read latency.
  logic [31:0] mem [0:255];
  logic [31:0] rdata_q = 32'h0;
  assign bus.m_rdata = rdata_q;
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.m_be[b]) mem[bus.m_addr[9:2]][b*8 +: 8] <= bus.m_wdata[b*8 +: 8];
      end else begin
        rdata_q <= mem[bus.m_addr[9:2]];
      end
    end
  end

  typedef struct {
    logic c_req; logic c_we; logic [31:0] c_addr; logic [31:0] c_wdata; logic [3:0] c_be;
    logic d_req; logic d_we; logic [31:0] d_addr; logic [31:0] d_wdata; logic [3:0] d_be;
    logic e_cg; logic e_dg; logic e_men; logic e_mwe;
    logic [31:0] e_maddr; logic [31:0] e_mwdata; logic [3:0] e_mbe;
    logic e_cv; logic [31:0] e_cr; logic e_dv; logic [31:0] e_dr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_be = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
  endtask

  task automatic reset_dut();
    tick();
    rst_n = 1'b1;
    drive_idle();
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic cq, input logic cw, input logic [31:0] ca, input logic [31:0] cd, input logic [3:0] cb,
    input logic dq, input logic dw, input logic [31:0] da, input logic [31:0] dd, input logic [3:0] db,
    input logic cg, input logic dg, input logic men, input logic mwe,
    input logic [31:0] ma, input logic [31:0] md, input logic [3:0] mb,
    input logic cv, input logic [31:0] cr, input logic dv, input logic [31:0] dr);
    vec_t v;
    v.c_req = cq; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd; v.c_be = cb;
    v.d_req = dq; v.d_we = dw; v.d_addr = da; v.d_wdata = dd; v.d_be = db;
    v.e_cg = cg; v.e_dg = dg; v.e_men = men; v.e_mwe = mwe;
    v.e_maddr = ma; v.e_mwdata = md; v.e_mbe = mb;
    v.e_cv = cv; v.e_cr = cr; v.e_dv = dv; v.e_dr = dr;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'hA0A0A0A0;
    mem[1]  = 32'hB1B1B1B1;
    mem[2]  = 32'hC2C2C2C2;
    mem[4]  = 32'hDEADBEEF;
    mem[12] = 32'hFFFFFFFF;

    //            c: req we addr wdata be | d: req we addr wdata be | cg dg men mwe maddr mwdata mbe | cv cr dv dr
    vecs[0]  = mk(1,0,32'h10,32'h0,4'hF,        0,0,32'h0,32'h0,4'h0,       1,0,1,0,32'h10,32'h0,4'hF,          0,32'h0,0,32'h0);
    vecs[1]  = mk(0,0,32'h0,32'h0,4'h0,         0,0,32'h0,32'h0,4'h0,       0,0,0,0,32'h0,32'h0,4'h0,           1,32'hDEADBEEF,0,32'h0);
    vecs[2]  = mk(1,1,32'h20,32'h12345678,4'hF, 0,0,32'h0,32'h0,4'h0,       1,0,1,1,32'h20,32'h12345678,4'hF,   0,32'h0,0,32'h0);
    vecs[3]  = mk(0,0,32'h0,32'h0,4'h0,         1,0,32'h20,32'h0,4'hF,      0,1,1,0,32'h20,32'h0,4'hF,          0,32'h0,0,32'h0);
    vecs[4]  = mk(0,0,32'h0,32'h0,4'h0,         0,0,32'h0,32'h0,4'h0,       0,0,0,0,32'h0,32'h0,4'h0,           0,32'h0,1,32'h12345678);
    vecs[5]  = mk(1,0,32'h0,32'h0,4'hF,         0,0,32'h0,32'h0,4'h0,       1,0,1,0,32'h0,32'h0,4'hF,           0,32'h0,0,32'h0);
    vecs[6]  = mk(0,0,32'h0,32'h0,4'h0,         1,0,32'h4,32'h0,4'hF,       0,1,1,0,32'h4,32'h0,4'hF,           1,32'hA0A0A0A0,0,32'h0);
    vecs[7]  = mk(1,0,32'h8,32'h0,4'hF,         0,0,32'h0,32'h0,4'h0,       1,0,1,0,32'h8,32'h0,4'hF,           0,32'h0,1,32'hB1B1B1B1);
    vecs[8]  = mk(0,0,32'h0,32'h0,4'h0,         0,0,32'h0,32'h0,4'h0,       0,0,0,0,32'h0,32'h0,4'h0,           1,32'hC2C2C2C2,0,32'h0);
    vecs[9]  = mk(0,0,32'h0,32'h0,4'h0,         1,1,32'h30,32'h0000AB00,4'h2, 0,1,1,1,32'h30,32'h0000AB00,4'h2, 0,32'h0,0,32'h0);
    vecs[10] = mk(0,0,32'h0,32'h0,4'h0,         1,0,32'h30,32'h0,4'hF,      0,1,1,0,32'h30,32'h0,4'hF,          0,32'h0,0,32'h0);
    vecs[11] = mk(0,0,32'h0,32'h0,4'h0,         0,0,32'h0,32'h0,4'h0,       0,0,0,0,32'h0,32'h0,4'h0,           0,32'h0,1,32'hFFFFABFF);
    vecs[12] = mk(0,1,32'h55,32'h77,4'hF,       0,1,32'h99,32'h88,4'hF,     0,0,0,0,32'h0,32'h0,4'h0,           0,32'h0,0,32'h0);

    rst_n = 1'b1;
    drive_idle();
    reset_dut();
    @(negedge clk);
    chk("reset_c_rvalid", 64'(bus.c_rvalid), 64'd0);
    chk("reset_d_rvalid", 64'(bus.d_rvalid), 64'd0);
    chk("reset_m_en",     64'(bus.m_en),     64'd0);
    chk("reset_c_rdata",  64'(bus.c_rdata),  64'd0);
    $display("reset: c_rvalid=%0b d_rvalid=%0b m_en=%0b", bus.c_rvalid, bus.d_rvalid, bus.m_en);

    for (int i = 0; i < 13; i++) begin
      tick();
      bus.c_req = vecs[i].c_req; bus.c_we = vecs[i].c_we; bus.c_addr = vecs[i].c_addr;
      bus.c_wdata = vecs[i].c_wdata; bus.c_be = vecs[i].c_be;
      bus.d_req = vecs[i].d_req; bus.d_we = vecs[i].d_we; bus.d_addr = vecs[i].d_addr;
      bus.d_wdata = vecs[i].d_wdata; bus.d_be = vecs[i].d_be;
      @(negedge clk);
      chk($sformatf("v%0d_c_gnt", i),    64'(bus.c_gnt),    64'(vecs[i].e_cg));
      chk($sformatf("v%0d_d_gnt", i),    64'(bus.d_gnt),    64'(vecs[i].e_dg));
      chk($sformatf("v%0d_m_en", i),     64'(bus.m_en),     64'(vecs[i].e_men));
      chk($sformatf("v%0d_m_we", i),     64'(bus.m_we),     64'(vecs[i].e_mwe));
      chk($sformatf("v%0d_m_addr", i),   64'(bus.m_addr),   64'(vecs[i].e_maddr));
      chk($sformatf("v%0d_m_wdata", i),  64'(bus.m_wdata),  64'(vecs[i].e_mwdata));
      chk($sformatf("v%0d_m_be", i),     64'(bus.m_be),     64'(vecs[i].e_mbe));
      chk($sformatf("v%0d_c_rvalid", i), 64'(bus.c_rvalid), 64'(vecs[i].e_cv));
      chk($sformatf("v%0d_c_rdata", i),  64'(bus.c_rdata),  64'(vecs[i].e_cr));
      chk($sformatf("v%0d_d_rvalid", i), 64'(bus.d_rvalid), 64'(vecs[i].e_dv));
      chk($sformatf("v%0d_d_rdata", i),  64'(bus.d_rdata),  64'(vecs[i].e_dr));
      $display("vec %0d: c_gnt=%0b d_gnt=%0b m_addr=%h c_rvalid=%0b c_rdata=%h d_rvalid=%0b d_rdata=%h",
               i, bus.c_gnt, bus.d_gnt, bus.m_addr, bus.c_rvalid, bus.c_rdata, bus.d_rvalid, bus.d_rdata);
    end

    // Sustained contention: C,C,C,C,D repeating.
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      if (i != 0) tick();
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h0; bus.c_be = 4'hF;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h4; bus.d_be = 4'hF;
      @(negedge clk);
      chk($sformatf("starve%0d_c_gnt", i), 64'(bus.c_gnt), 64'(i % 5 != 4));
      chk($sformatf("starve%0d_d_gnt", i), 64'(bus.d_gnt), 64'(i % 5 == 4));
      chk($sformatf("starve%0d_both", i),  64'(bus.c_gnt & bus.d_gnt), 64'd0);
      $display("contend %0d: c_gnt=%0b d_gnt=%0b", i, bus.c_gnt, bus.d_gnt);
    end

    // Reset while a core read is in flight; starvation count must restart at zero.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h10; bus.c_be = 4'hF;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h4;  bus.d_be = 4'hF;
      @(negedge clk);
      chk($sformatf("pre%0d_c_gnt", i), 64'(bus.c_gnt), 64'd1);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstN_c_gnt", 64'(bus.c_gnt), 64'd1);
    $display("cycle N: rst=1 c_gnt=%0b", bus.c_gnt);
    tick();
    @(negedge clk);
    chk("rstN1_c_rvalid", 64'(bus.c_rvalid), 64'd0);
    chk("rstN1_c_gnt",    64'(bus.c_gnt),    64'd1);
    chk("rstN1_d_gnt",    64'(bus.d_gnt),    64'd0);
    $display("cycle N+1: c_rvalid=%0b c_gnt=%0b d_gnt=%0b", bus.c_rvalid, bus.c_gnt, bus.d_gnt);
    for (int i = 0; i < 5; i++) begin
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      if (i == 0) chk("rstN2_c_rvalid", 64'(bus.c_rvalid), 64'd0);
      chk($sformatf("post%0d_c_gnt", i), 64'(bus.c_gnt), 64'(i != 4));
      chk($sformatf("post%0d_d_gnt", i), 64'(bus.d_gnt), 64'(i == 4));
      $display("after reset %0d: c_rvalid=%0b c_gnt=%0b d_gnt=%0b", i, bus.c_rvalid, bus.c_gnt, bus.d_gnt);
    end

    tick();
    drive_idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
